// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes and FSM state encoding for alu_seq
// Purpose: opcode constants (OP_FWD..OP_MUL) and the two-state FSM type.
package alu_seq_pkg;

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// rtl/alu_seq_comb.sv - combinational single-cycle unit (FORWARD/ADD/AND/OR/SUB)
// Ports:
//   sel   in  3      opcode
//   a     in  WIDTH  operand A
//   b     in  WIDTH  operand B
//   y     out WIDTH  result (FORWARD of b for opcodes this unit does not handle)
//   carry out 1      ADD carry-out / SUB borrow, else 0
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit: carry-out for ADD, and for SUB the top bit goes high
  // exactly when a < b unsigned (borrow).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = b;
    carry = 1'b0;
    case (sel)
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_SUB: begin
        y     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
      end
      default: y = b;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ALU with iterative shifts and shift-add multiply
// Ports:
//   CLK    in  1      rising-edge clock
//   RESET  in  1      synchronous active-high reset
//   START  in  1      request, sampled only in IDLE
//   SELECT in  3      opcode, sampled with START
//   DATA1  in  WIDTH  operand A
//   DATA2  in  WIDTH  operand B / shift amount (low SHW bits)
//   RESULT out WIDTH  registered result
//   ZERO   out 1      RESULT == 0
//   CARRY  out 1      ADD carry / SUB borrow, else 0
//   BUSY   out 1      high while a multi-cycle op runs
//   DONE   out 1      one-cycle pulse when RESULT/flags were just updated
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       SELECT,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             CARRY,
  output logic             BUSY,
  output logic             DONE
);

  // Count must reach WIDTH for MUL, one more than a shift amount can hold.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_next;
  logic [2:0]       run_op;
  logic [WIDTH-1:0] work;      // shift operand, or multiplicand for MUL
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  logic [SHW-1:0]   amt;
  logic             is_shift;
  logic             multi;
  logic             last;
  logic [WIDTH-1:0] comb_y;
  logic             comb_c;
  logic [WIDTH-1:0] work_step;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] fin_val;

  assign amt      = DATA2[SHW-1:0];
  assign is_shift = (SELECT == OP_SLL) || (SELECT == OP_SRA);
  assign multi    = START && ((is_shift && (amt != '0)) || (SELECT == OP_MUL));
  assign last     = (count == CW'(1));
  assign BUSY     = (state == S_RUN);

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .sel   (SELECT),
    .a     (DATA1),
    .b     (DATA2),
    .y     (comb_y),
    .carry (comb_c)
  );

  // SLL and the MUL multiplicand both shift left by one per step.
  assign work_step = (run_op == OP_SRA) ? {work[WIDTH-1], work[WIDTH-1:1]}
                                        : {work[WIDTH-2:0], 1'b0};
  assign acc_step  = acc + (mplier[0] ? work : '0);
  assign fin_val   = (run_op == OP_MUL) ? acc_step : work_step;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (multi) state_next = S_RUN;
      S_RUN:   if (last)  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      RESULT <= '0;
      ZERO   <= 1'b1;
      CARRY  <= 1'b0;
      DONE   <= 1'b0;
      run_op <= OP_FWD;
      work   <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      DONE  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            run_op <= SELECT;
            if (multi) begin
              work   <= DATA1;
              mplier <= DATA2;
              acc    <= '0;
              count  <= (SELECT == OP_MUL) ? CW'(WIDTH) : CW'(amt);
            end else if (is_shift) begin
              // Zero-amount shift completes like a single-cycle op.
              RESULT <= DATA1;
              ZERO   <= (DATA1 == '0);
              CARRY  <= 1'b0;
              DONE   <= 1'b1;
            end else begin
              RESULT <= comb_y;
              ZERO   <= (comb_y == '0);
              CARRY  <= comb_c;
              DONE   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          work   <= work_step;
          mplier <= mplier >> 1;
          acc    <= acc_step;
          count  <= count - CW'(1);
          if (last) begin
            RESULT <= fin_val;
            ZERO   <= (fin_val == '0);
            CARRY  <= 1'b0;
            DONE   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=8 and WIDTH=16
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start [2];
  logic [2:0]  sel   [2];
  logic [31:0] d1    [2];
  logic [31:0] d2    [2];

  logic [7:0]  r8;
  logic        z8, c8, b8, dn8;
  logic [15:0] r16;
  logic        z16, c16, b16, dn16;

  logic [31:0] res_o  [2];
  logic        zero_o [2];
  logic        car_o  [2];
  logic        busy_o [2];
  logic        done_o [2];

  assign res_o[0]  = {24'b0, r8};
  assign res_o[1]  = {16'b0, r16};
  assign zero_o[0] = z8;
  assign zero_o[1] = z16;
  assign car_o[0]  = c8;
  assign car_o[1]  = c16;
  assign busy_o[0] = b8;
  assign busy_o[1] = b16;
  assign done_o[0] = dn8;
  assign done_o[1] = dn16;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RESET(rst), .START(start[0]), .SELECT(sel[0]),
    .DATA1(d1[0][7:0]), .DATA2(d2[0][7:0]),
    .RESULT(r8), .ZERO(z8), .CARRY(c8), .BUSY(b8), .DONE(dn8)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .CLK(clk), .RESET(rst), .START(start[1]), .SELECT(sel[1]),
    .DATA1(d1[1][15:0]), .DATA2(d2[1][15:0]),
    .RESULT(r16), .ZERO(z16), .CARRY(c16), .BUSY(b16), .DONE(dn16)
  );

  int vec  = 0;
  int errs = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     wdt    [2] = '{8, 16};
  longint m_res  [2] = '{0, 0};
  bit     m_zero [2] = '{1, 1};
  bit     m_car  [2] = '{0, 0};
  bit     m_done [2] = '{0, 0};
  bit     m_busy [2] = '{0, 0};
  int     m_left [2] = '{0, 0};
  longint m_pres [2] = '{0, 0};
  bit     m_pcar [2] = '{0, 0};

  // Result, carry and total latency (START edge to DONE cycle) of one op.
  function automatic void compute(input int w, input logic [2:0] s,
                                  input longint a_in, input longint b_in,
                                  output longint r, output bit c, output int lat);
    longint mask = (longint'(1) << w) - 1;
    longint a = a_in & mask;
    longint b = b_in & mask;
    longint sa;
    int n = int'(b % w);
    c = 0;
    lat = 1;
    case (s)
      3'd0: r = b;
      3'd1: begin r = (a + b) & mask; c = ((a + b) >> w) != 0; end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = (a - b) & mask; c = (a < b); end
      3'd5: begin r = (a << n) & mask; lat = n + 1; end
      3'd6: begin
        sa = ((a >> (w - 1)) & 1) != 0 ? a - (longint'(1) << w) : a;
        r = (sa >>> n) & mask;
        lat = n + 1;
      end
      default: begin r = (a * b) & mask; lat = w + 1; end
    endcase
  endfunction

  always @(posedge clk) begin
    longint r;
    bit     c;
    int     lat;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_res[d] = 0; m_zero[d] = 1; m_car[d] = 0;
        m_done[d] = 0; m_busy[d] = 0; m_left[d] = 0;
      end else begin
        m_done[d] = 0;
        if (m_busy[d]) begin
          m_left[d]--;
          if (m_left[d] == 0) begin
            m_busy[d] = 0;
            m_res[d]  = m_pres[d];
            m_car[d]  = m_pcar[d];
            m_zero[d] = (m_pres[d] == 0);
            m_done[d] = 1;
          end
        end else if (start[d]) begin
          compute(wdt[d], sel[d], longint'(d1[d]), longint'(d2[d]), r, c, lat);
          if (lat == 1) begin
            m_res[d] = r; m_car[d] = c; m_zero[d] = (r == 0); m_done[d] = 1;
          end else begin
            m_pres[d] = r; m_pcar[d] = c; m_busy[d] = 1; m_left[d] = lat - 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("w%0d_done", wdt[d]),   longint'(done_o[d]), longint'(m_done[d]));
        chk($sformatf("w%0d_busy", wdt[d]),   longint'(busy_o[d]), longint'(m_busy[d]));
        chk($sformatf("w%0d_result", wdt[d]), longint'(res_o[d]),  m_res[d]);
        chk($sformatf("w%0d_zero", wdt[d]),   longint'(zero_o[d]), longint'(m_zero[d]));
        chk($sformatf("w%0d_carry", wdt[d]),  longint'(car_o[d]),  longint'(m_car[d]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input string nm, input int d, input logic [2:0] s,
                        input logic [31:0] a, input logic [31:0] b,
                        input longint er, input bit ez, input bit ec, input int el);
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    sel[d] = s; d1[d] = a; d2[d] = b; start[d] = 1'b1;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      start[d] = 1'b0;
      if (done_o[d]) seen = 1;
    end
    chk({nm, "_seen"},    longint'(seen), 1);
    chk({nm, "_latency"}, longint'(lat), longint'(el));
    chk({nm, "_result"},  longint'(res_o[d]), er);
    chk({nm, "_zero"},    longint'(zero_o[d]), longint'(ez));
    chk({nm, "_carry"},   longint'(car_o[d]), longint'(ec));
  endtask

  initial begin
    int ndone;
    int done_at;
    longint done_res;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; sel[d] = 3'd0; d1[d] = '0; d2[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_result", longint'(r8), 0);
    chk("reset_zero",   longint'(z8), 1);
    chk("reset_carry",  longint'(c8), 0);
    chk("reset_busy",   longint'(b8), 0);
    chk("reset_done",   longint'(dn8), 0);
    rst = 1'b0;
    chk_en = 1;

    run_op("add_f0_20",  0, 3'b001, 32'hF0, 32'h20, 'h10, 0, 1, 1);
    run_op("sub_5_5",    0, 3'b100, 32'h05, 32'h05, 'h00, 1, 0, 1);
    run_op("sub_3_5",    0, 3'b100, 32'h03, 32'h05, 'hFE, 0, 1, 1);
    run_op("sra_90_3",   0, 3'b110, 32'h90, 32'h03, 'hF2, 0, 0, 4);
    run_op("sll_81_0",   0, 3'b101, 32'h81, 32'h00, 'h81, 0, 0, 1);
    run_op("sll_81_9",   0, 3'b101, 32'h81, 32'h09, 'h02, 0, 0, 2);
    run_op("mul_13_11",  0, 3'b111, 32'd13, 32'd11, 'h8F, 0, 0, 9);
    run_op("mul_10_10",  0, 3'b111, 32'h10, 32'h10, 'h00, 1, 0, 9);

    // START during RUN is ignored: exactly one DONE, carrying the MUL result.
    @(negedge clk);
    sel[0] = 3'b111; d1[0] = 32'd13; d2[0] = 32'd11; start[0] = 1'b1;
    ndone = 0; done_at = 0; done_res = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (k == 3) begin
        sel[0] = 3'b001; d1[0] = 32'h01; d2[0] = 32'h02; start[0] = 1'b1;
      end
      if (dn8) begin
        ndone++; done_at = k; done_res = longint'(r8);
      end
    end
    chk("ignore_start_ndone",  longint'(ndone), 1);
    chk("ignore_start_at",     longint'(done_at), 9);
    chk("ignore_start_result", done_res, 'h8F);

    // Reset in the middle of a MUL discards it.
    @(negedge clk);
    sel[0] = 3'b111; d1[0] = 32'h12; d2[0] = 32'h34; start[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy",   longint'(b8), 0);
    chk("midrst_result", longint'(r8), 0);
    chk("midrst_zero",   longint'(z8), 1);
    chk("midrst_done",   longint'(dn8), 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (dn8) ndone++;
    end
    chk("midrst_no_done", longint'(ndone), 0);
    run_op("fwd_3c", 0, 3'b000, 32'h00, 32'h3C, 'h3C, 0, 0, 1);

    // WIDTH=16: back-to-back OR then AND, DONE on consecutive cycles.
    @(negedge clk);
    sel[1] = 3'b011; d1[1] = 32'h0F0F; d2[1] = 32'h00FF; start[1] = 1'b1;
    @(negedge clk);
    chk("b2b_or_done",   longint'(dn16), 1);
    chk("b2b_or_result", longint'(r16), 'h0FFF);
    sel[1] = 3'b010; d1[1] = 32'hFF00; d2[1] = 32'h0FF0;
    @(negedge clk);
    start[1] = 1'b0;
    chk("b2b_and_done",   longint'(dn16), 1);
    chk("b2b_and_result", longint'(r16), 'h0F00);
    @(negedge clk);
    chk("b2b_idle_done", longint'(dn16), 0);

    run_op("w16_sra_8000_15", 1, 3'b110, 32'h8000, 32'd15, 'hFFFF, 0, 0, 16);
    run_op("w16_add_ffff_1",  1, 3'b001, 32'hFFFF, 32'h0001, 'h0000, 1, 1, 1);
    run_op("w16_mul_300_300", 1, 3'b111, 32'd300, 32'd300, 'h5F90, 0, 0, 17);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
